// File: rtl/e_mdu_sequencer_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer.
// Holds the MD op encodings and the default latency constants.
package e_mdu_sequencer_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;
  localparam int MDU_CNT_W_DEF       = 4;

endpackage

// File: rtl/e_mdu_sequencer_md_latency_counter.sv
// Down-counter timing one multi-cycle MD operation.
// Loads N, counts down to zero and flags the final busy cycle.
module md_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  // done marks the last busy cycle; the result commits on its closing edge
  assign done = (cnt == ONE);

endmodule

// File: rtl/e_mdu_sequencer.sv
// Execute-stage multiply/divide controller: owns HI/LO, captures the
// 64-bit result at start and commits it when the latency counter expires.
module e_mdu_sequencer
  import e_mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
  parameter int CNT_W       = MDU_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_MDUOp,
  input  logic        E_Req,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  output logic        E_Busy,
  output logic        E_MDOccupied,
  output logic [31:0] E_RDHI,
  output logic [31:0] E_RDLO
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  // {remainder, quotient}; the one overflowing case is pinned explicitly
  function automatic logic [63:0] sdiv(input logic signed [31:0] a,
                                       input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'sd0) return 64'd0;
    if (a == 32'sh8000_0000 && b == -32'sd1) return {32'h0, 32'h8000_0000};
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  function automatic logic [63:0] udiv(input logic [31:0] a,
                                       input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  md_state_e          state_q, state_d;
  logic               e_start;
  logic               mt_ok;
  logic               is_arith;
  logic               is_div;
  logic               done;
  logic [CNT_W-1:0]   load_n;
  logic signed [63:0] rs_s64, rt_s64;
  logic [63:0]        rs_u64, rt_u64;
  logic [63:0]        calc;
  logic [63:0]        result_p1;
  logic               nowrite_p1;
  logic [31:0]        hi_q, lo_q;

  assign is_div   = (E_MDUOp == MDU_DIV) || (E_MDUOp == MDU_DIVU);
  assign is_arith = (E_MDUOp == MDU_MULT) || (E_MDUOp == MDU_MULTU) || is_div;
  assign E_Busy   = (state_q == MD_BUSY);
  assign mt_ok    = !E_Busy && !E_Req;
  assign e_start  = is_arith && mt_ok;
  assign load_n   = is_div ? DIV_N : MULT_N;

  assign E_MDOccupied = e_start || E_Busy;
  assign E_RDHI       = hi_q;
  assign E_RDLO       = lo_q;

  assign rs_s64 = {{32{E_RS[31]}}, E_RS};
  assign rt_s64 = {{32{E_RT[31]}}, E_RT};
  assign rs_u64 = {32'd0, E_RS};
  assign rt_u64 = {32'd0, E_RT};

  always_comb begin
    calc = 64'd0;
    case (E_MDUOp)
      MDU_MULT:  calc = rs_s64 * rt_s64;
      MDU_MULTU: calc = rs_u64 * rt_u64;
      MDU_DIV:   calc = sdiv(E_RS, E_RT);
      MDU_DIVU:  calc = udiv(E_RS, E_RT);
      default:   calc = 64'd0;
    endcase
  end

  md_latency_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (e_start),
    .load_val (load_n),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (e_start) state_d = MD_BUSY;
      MD_BUSY: if (done)    state_d = MD_IDLE;
      default:              state_d = MD_IDLE;
    endcase
  end

  // p1: pending result held for the busy window, committed on done
  always_ff @(posedge clk) begin
    if (reset) begin
      result_p1  <= 64'd0;
      nowrite_p1 <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      if (e_start) begin
        result_p1  <= calc;
        nowrite_p1 <= is_div && (E_RT == 32'd0);
      end
      if (E_Busy && done) begin
        if (!nowrite_p1) begin
          hi_q <= result_p1[63:32];
          lo_q <= result_p1[31:0];
        end
      end else if (mt_ok && E_MDUOp == MDU_MTHI) begin
        hi_q <= E_RS;
      end else if (mt_ok && E_MDUOp == MDU_MTLO) begin
        lo_q <= E_RS;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu_sequencer.sv
// Directed bench for e_mdu_sequencer with hand-computed HI/LO expectations.
module tb_e_mdu_sequencer;
  import e_mdu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  E_MDUOp;
  logic        E_Req;
  logic [31:0] E_RS, E_RT;
  logic        E_Busy, E_MDOccupied;
  logic [31:0] E_RDHI, E_RDLO;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] exp_hi, exp_lo;

  e_mdu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .E_MDUOp      (E_MDUOp),
    .E_Req        (E_Req),
    .E_RS         (E_RS),
    .E_RT         (E_RT),
    .E_Busy       (E_Busy),
    .E_MDOccupied (E_MDOccupied),
    .E_RDHI       (E_RDHI),
    .E_RDLO       (E_RDLO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue one arithmetic op, count its busy cycles, check the committed result
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input int exp_n, input logic [31:0] hi, input logic [31:0] lo);
    int n;
    E_MDUOp = op; E_RS = rs; E_RT = rt;
    #1;
    chk({tag, "_occ_start"}, {31'd0, E_MDOccupied}, 32'd1);
    step();
    E_MDUOp = MDU_NONE;
    chk({tag, "_hi_hold"}, E_RDHI, exp_hi);
    chk({tag, "_lo_hold"}, E_RDLO, exp_lo);
    n = 0;
    while (E_Busy && n < 20) begin
      n++;
      step();
    end
    chk({tag, "_busy_n"}, n, exp_n);
    chk({tag, "_hi"}, E_RDHI, hi);
    chk({tag, "_lo"}, E_RDLO, lo);
    exp_hi = hi; exp_lo = lo;
  endtask

  initial begin
    int n;
    reset = 1'b1; E_MDUOp = MDU_NONE; E_Req = 1'b0; E_RS = '0; E_RT = '0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, E_Busy}, 32'd0);
    chk("rst_occ",  {31'd0, E_MDOccupied}, 32'd0);
    chk("rst_hi",   E_RDHI, 32'd0);
    chk("rst_lo",   E_RDLO, 32'd0);

    run_op("mult",  MDU_MULT,  32'hFFFF_FFFF, 32'd2, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5,  32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  MDU_DIVU,  32'd7,         32'd2, 10, 32'd1,         32'd3);
    run_op("divov", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("div0",  MDU_DIVU,  32'd5,         32'd0, 10, 32'd0,         32'h8000_0000);

    E_MDUOp = MDU_MTLO; E_RS = 32'h1234;
    #1;
    chk("mtlo_occ", {31'd0, E_MDOccupied}, 32'd0);
    step();
    E_MDUOp = MDU_NONE;
    chk("mtlo_lo",   E_RDLO, 32'h1234);
    chk("mtlo_busy", {31'd0, E_Busy}, 32'd0);
    exp_lo = 32'h1234;

    // mthi and a second mult arrive while busy; both must be ignored
    E_MDUOp = MDU_MULT; E_RS = 32'd3; E_RT = 32'd5;
    step();
    n = 0;
    E_MDUOp = MDU_MTHI; E_RS = 32'hDEAD_BEEF;
    if (E_Busy) n++;
    step();
    E_MDUOp = MDU_MULT; E_RS = 32'd100; E_RT = 32'd100;
    chk("mthi_busy_hi", E_RDHI, 32'd0);
    if (E_Busy) n++;
    step();
    E_MDUOp = MDU_NONE;
    while (E_Busy && n < 20) begin
      n++;
      step();
    end
    chk("busy_ign_n",  n, 5);
    chk("busy_ign_hi", E_RDHI, 32'd0);
    chk("busy_ign_lo", E_RDLO, 32'd15);
    exp_hi = 32'd0; exp_lo = 32'd15;

    E_MDUOp = MDU_MULT; E_RS = 32'd9; E_RT = 32'd9; E_Req = 1'b1;
    #1;
    chk("req_occ", {31'd0, E_MDOccupied}, 32'd0);
    step();
    E_MDUOp = MDU_NONE; E_Req = 1'b0;
    chk("req_busy", {31'd0, E_Busy}, 32'd0);
    step(); step(); step(); step(); step();
    chk("req_hi", E_RDHI, exp_hi);
    chk("req_lo", E_RDLO, exp_lo);

    E_MDUOp = MDU_DIV; E_RS = 32'd100; E_RT = 32'd7;
    step();
    E_MDUOp = MDU_NONE;
    step(); step();
    chk("rst_mid_busy_pre", {31'd0, E_Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, E_Busy}, 32'd0);
    chk("rst_mid_hi",   E_RDHI, 32'd0);
    chk("rst_mid_lo",   E_RDLO, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    step(); step(); step(); step(); step(); step(); step(); step(); step(); step();
    chk("rst_mid_lo_late", E_RDLO, 32'd0);

    run_op("mult34", MDU_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/e_mdu_sequencer.md
Name: e_mdu_sequencer

Overview:
- Execute-stage multiply/divide unit controller; owns the HI/LO register pair and sequences the multi-cycle latency.
- Accepts one MD operation per start from the E-stage decode: mult, multu, div, divu, mthi or mtlo.
- Drives E_Busy and E_MDOccupied to the hazard unit; drives E_RDHI and E_RDLO to the E-stage HI/LO read select.
- Suppresses starts when the E-stage instruction is being flushed by an exception or interrupt.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult and multu (must be at least 1).
- DIV_CYCLES, 10, number of Busy cycles for div and divu (must be at least 1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- E_MDUOp  in  3  op code from the shared package; MDU_NONE means no MD operation.
- E_Req  in  1  exception/interrupt flush of the E-stage instruction; blocks any start this cycle.
- E_RS  in  32  operand A (dividend/multiplicand; mthi/mtlo source).
- E_RT  in  32  operand B (divisor/multiplier).
- E_Busy  out  1  operation in flight.
- E_MDOccupied  out  1  E_Start OR E_Busy; the hazard unit stalls D-stage MD instructions on this.
- E_RDHI  out  32  HI register.
- E_RDLO  out  32  LO register.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: E_Busy=0, counter=0, HI=0, LO=0, pending result=0.
- Reset priority: reset wins over every other input, including mid-operation; the in-flight result is discarded.
- Start condition (combinational E_Start) is all of:
  - E_MDUOp ∈ {MULT, MULTU, DIV, DIVU};
  - E_Busy=0;
  - E_Req=0.
- States: IDLE (E_Busy=0) and BUSY (E_Busy=1).
  - IDLE→BUSY on E_Start at edge T. At that edge:
    - counter loads N = MULT_CYCLES or DIV_CYCLES;
    - the full 64-bit result is computed from E_RS/E_RT and captured into the pending register.
  - E_Busy is high for exactly N cycles, T+1..T+N.
  - Counter decrements each BUSY cycle. On the edge where counter==1:
    - HI/LO load the pending result;
    - E_Busy falls;
    - the new values are visible from cycle T+N+1.
  - BUSY→IDLE only via completion or reset.
- mthi/mtlo:
  - Accepted only when E_Busy=0 and E_Req=0.
  - HI (or LO) := E_RS at the next edge; no Busy cycle.
  - Ignored while busy; the hazard unit already stalls these.
- Any op arriving while E_Busy=1: ignored, no state change.
- Arithmetic:
  - mult: signed 32×32 → 64; HI=product[63:32], LO=product[31:0].
  - multu: unsigned 32×32 → 64, same HI/LO split.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): full DIV_CYCLES Busy sequence runs; HI/LO unchanged at completion.
- E_MDOccupied is combinational: it goes high in the start cycle itself, so a back-to-back MD instruction in D stalls with no bubble gap.
- E_RDHI/E_RDLO: direct register outputs; they hold old values throughout BUSY.

Decomposition:
- Shared package holds:
  - op encodings: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6;
  - default cycle-count constants.
- One natural sub-module: md_latency_counter (load N, decrement, done pulse).
- Arithmetic stays inline.

Test Plan:
- mult E_RS=0xFFFFFFFF, E_RT=2 → E_Busy high cycles T+1..T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE at T+6.
- div −7/2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 → LO=3, HI=1.
  - div 0x80000000 / −1 → LO=0x80000000, HI=0.
  - divu 5/0 → HI/LO unchanged, Busy for 10 cycles.
- mtlo E_RS=0x1234 while idle → LO=0x1234 next cycle, E_Busy stays 0.
  - mthi issued during BUSY → HI unchanged.
  - mult issued during BUSY → counter unaffected.
- mult with E_Req=1 → E_Busy stays 0, E_MDOccupied=0, HI/LO unchanged.
- reset asserted in the 3rd Busy cycle of div → next cycle E_Busy=0, HI=LO=0; a following mult 3×4 completes with LO=12, HI=0.
